// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester channels and the RAM port around the arbiter.
// The slave view belongs to the arbiter. The master view belongs to whatever
// drives the requests and models the RAM.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  // fetch channel
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  // load/store channel
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  // shared read data and status
  logic [DW-1:0] rdata;
  logic          msel;
  logic          busy;
  // RAM port
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_dout,
    output if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata, msel, busy,
           mem_addr, mem_write, mem_din
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_dout,
    input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata, msel, busy,
           mem_addr, mem_write, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for the multi-cycle CPU.
// It shares the RAM between instruction fetch and load/store. Only one access
// is in flight at a time. Contention is resolved round-robin against the last
// owner. Read data is returned through a registered rdata with a one-cycle
// valid strobe. The strobe is routed to the owner recorded in msel.
module mem_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 1   // legal 1..3
) (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active-low
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          msel_q, msel_d;        // owner of the current/last access, 1 = ls
  logic          we_q, we_d;            // current access is a store
  logic          last_ls_q, last_ls_d;  // last grant went to ls
  logic          rvalid_q, rvalid_d;
  logic          pick_ls;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // samples the pre-edge values, so the order of these statements does not matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      msel_q    <= 1'b0;
      we_q      <= 1'b0;
      last_ls_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
      msel_q    <= msel_d;
      we_q      <= we_d;
      last_ls_q <= last_ls_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Next-state logic: arbitration, access sequencing and read capture.
  always_comb begin
    // NOTE: every signal written below gets a hold value first. Any branch
    // that leaves it untouched keeps the register value and infers no latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
    msel_d    = msel_q;
    we_d      = we_q;
    last_ls_d = last_ls_q;
    rvalid_d  = (state_q == S_RESP);
    pick_ls   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          // A lone requester wins. Under contention the port not granted last wins.
          pick_ls   = bus.ls_req && (!bus.if_req || !last_ls_q);
          addr_d    = pick_ls ? bus.ls_addr : bus.if_addr;
          din_d     = pick_ls ? bus.ls_wdata : din_q;
          msel_d    = pick_ls;
          we_d      = pick_ls && bus.ls_we;
          last_ls_d = pick_ls;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else if (RD_LAT == 1) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd1) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        rdata_d = bus.mem_dout;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only. msel_q still names the owner
  // in the rvalid cycle, because the next arbitration registers at its end.
  assign bus.if_gnt    = (state_q == S_ACCESS) && !msel_q;
  assign bus.ls_gnt    = (state_q == S_ACCESS) &&  msel_q;
  assign bus.mem_write = (state_q == S_ACCESS) &&  we_q;
  assign bus.if_rvalid = rvalid_q && !msel_q;
  assign bus.ls_rvalid = rvalid_q &&  msel_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;
  assign bus.msel      = msel_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The bench has two instances: dut1 with
// RD_LAT=1 and dut3 with RD_LAT=3. Each has its own behavioural RAM with
// matching read latency.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset1, reset3;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(8), .DW(16)) b1 ();
  mem_port_arbiter_if #(.AW(8), .DW(16)) b3 ();

  mem_port_arbiter #(.AW(8), .DW(16), .RD_LAT(1)) dut1 (.clk(clk), .reset(reset1), .bus(b1));
  mem_port_arbiter #(.AW(8), .DW(16), .RD_LAT(3)) dut3 (.clk(clk), .reset(reset3), .bus(b3));

  // RAM models: write on strobe, read data RD_LAT cycles after the address cycle.
  logic [15:0] ram1 [256];
  logic [15:0] ram3 [256];
  logic [15:0] p1, p3a, p3b, p3c;
  logic        poke1_en = 1'b0, poke3_en = 1'b0;
  logic [7:0]  poke_a;
  logic [15:0] poke_d;

  always @(posedge clk) begin
    if (poke1_en) ram1[poke_a] <= poke_d;
    else if (b1.mem_write) ram1[b1.mem_addr] <= b1.mem_din;
    p1 <= ram1[b1.mem_addr];
  end

  always @(posedge clk) begin
    if (poke3_en) ram3[poke_a] <= poke_d;
    else if (b3.mem_write) ram3[b3.mem_addr] <= b3.mem_din;
    p3a <= ram3[b3.mem_addr];
    p3b <= p3a;
    p3c <= p3b;
  end

  assign b1.mem_dout = p1;
  assign b3.mem_dout = p3c;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_WAIT = 2'd2, ST_RESP = 2'd3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic which3, input logic [7:0] a, input logic [15:0] d);
    poke_a = a; poke_d = d;
    if (which3) poke3_en = 1'b1; else poke1_en = 1'b1;
    step();
    poke1_en = 1'b0; poke3_en = 1'b0;
  endtask

  task automatic test_reset();
    reset1 = 1'b0; reset3 = 1'b0;
    b1.if_req = 0; b1.if_addr = '0; b1.ls_req = 0; b1.ls_we = 0; b1.ls_addr = '0; b1.ls_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.ls_req = 0; b3.ls_we = 0; b3.ls_addr = '0; b3.ls_wdata = '0;
    poke(1'b0, 8'h05, 16'hD2A5);
    poke(1'b0, 8'h30, 16'hA1A1);
    poke(1'b0, 8'h31, 16'hB2B2);
    poke(1'b1, 8'h20, 16'hBEEF);
    poke(1'b1, 8'h21, 16'h5A5A);
    poke(1'b1, 8'h22, 16'h0F0F);
    n_cmp++;
    if ({b1.busy, b1.if_gnt, b1.ls_gnt, b1.if_rvalid, b1.ls_rvalid, b1.mem_write, b1.msel} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000000",
        {b1.busy, b1.if_gnt, b1.ls_gnt, b1.if_rvalid, b1.ls_rvalid, b1.mem_write, b1.msel});
    end
    n_cmp++;
    if ({b1.mem_addr, b1.mem_din, b1.rdata} !== 40'h0) begin
      n_bad++; $display("FAIL reset_data: addr %h din %h rdata %h want 0", b1.mem_addr, b1.mem_din, b1.rdata);
    end
    reset1 = 1'b1; reset3 = 1'b1;
    step();
    n_cmp++;
    if (b1.busy !== 1'b0 || b3.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: busy1 %b busy3 %b want 0", b1.busy, b3.busy);
    end
  endtask

  task automatic test_fetch();
    b1.if_req = 1'b1; b1.if_addr = 8'h05;
    step();  // ACCESS
    n_cmp++;
    if ({b1.if_gnt, b1.ls_gnt, b1.msel, b1.mem_addr} !== {3'b100, 8'h05}) begin
      n_bad++; $display("FAIL fetch_access: gnt %b/%b msel %b addr %h want 1/0 0 05",
        b1.if_gnt, b1.ls_gnt, b1.msel, b1.mem_addr);
    end
    b1.if_req = 1'b0;
    step();  // RESP
    n_cmp++;
    if ({b1.if_gnt, b1.if_rvalid, b1.busy} !== 3'b001) begin
      n_bad++; $display("FAIL fetch_resp: gnt %b rvalid %b busy %b want 0 0 1", b1.if_gnt, b1.if_rvalid, b1.busy);
    end
    step();  // IDLE, rvalid
    n_cmp++;
    if ({b1.if_rvalid, b1.ls_rvalid, b1.rdata} !== {2'b10, 16'hD2A5}) begin
      n_bad++; $display("FAIL fetch_rvalid: if %b ls %b rdata %h want 1 0 d2a5", b1.if_rvalid, b1.ls_rvalid, b1.rdata);
    end
    step();
    n_cmp++;
    if ({b1.if_rvalid, b1.ls_rvalid, b1.rdata} !== {2'b00, 16'hD2A5}) begin
      n_bad++; $display("FAIL fetch_after: if %b ls %b rdata %h want 0 0 d2a5", b1.if_rvalid, b1.ls_rvalid, b1.rdata);
    end
  endtask

  task automatic test_store();
    int writes = 0;
    int rvs = 0;
    b1.ls_req = 1'b1; b1.ls_we = 1'b1; b1.ls_addr = 8'h10; b1.ls_wdata = 16'h1234;
    step();  // ACCESS
    n_cmp++;
    if ({b1.mem_write, b1.ls_gnt, b1.msel, b1.mem_addr, b1.mem_din} !== {3'b111, 8'h10, 16'h1234}) begin
      n_bad++; $display("FAIL store_access: we %b gnt %b msel %b addr %h din %h want 1 1 1 10 1234",
        b1.mem_write, b1.ls_gnt, b1.msel, b1.mem_addr, b1.mem_din);
    end
    b1.ls_req = 1'b0; b1.ls_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      writes += int'(b1.mem_write);
      rvs    += int'(b1.ls_rvalid) + int'(b1.if_rvalid);
    end
    n_cmp++;
    if (writes != 0 || rvs != 0) begin
      n_bad++; $display("FAIL store_after: extra writes %0d rvalids %0d want 0 0", writes, rvs);
    end
    b1.if_req = 1'b1; b1.if_addr = 8'h10;
    step();
    b1.if_req = 1'b0;
    step();
    step();
    n_cmp++;
    if ({b1.if_rvalid, b1.rdata} !== {1'b1, 16'h1234}) begin
      n_bad++; $display("FAIL store_readback: rvalid %b rdata %h want 1 1234", b1.if_rvalid, b1.rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ls [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int   ng = 0;
    int   nrv = 0;
    logic pb = 1'b0, pb2 = 1'b0;
    b1.ls_req = 1'b1; b1.ls_we = 1'b0; b1.ls_addr = 8'h30;
    b1.if_req = 1'b1; b1.if_addr = 8'h31;
    for (int c = 0; c < 14; c++) begin
      step();
      n_cmp++;
      if ((b1.if_gnt && b1.ls_gnt) || (b1.if_rvalid && b1.ls_rvalid)) begin
        n_bad++; $display("FAIL b2b_overlap: cycle %0d gnt %b/%b rvalid %b/%b want no overlap",
          c, b1.if_gnt, b1.ls_gnt, b1.if_rvalid, b1.ls_rvalid);
      end
      if (b1.if_gnt || b1.ls_gnt) begin
        if (ng < 4) begin
          n_cmp++;
          if (b1.ls_gnt !== exp_ls[ng]) begin
            n_bad++; $display("FAIL b2b_order: grant %0d ls_gnt %b want %b", ng, b1.ls_gnt, exp_ls[ng]);
          end
        end
        if (ng > 0) begin
          n_cmp++;
          if ({pb2, pb} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_gap: grant %0d busy history %b want 10", ng, {pb2, pb});
          end
        end
        ng++;
        if (ng == 4) begin
          b1.ls_req = 1'b0; b1.if_req = 1'b0;
        end
      end
      if (b1.ls_rvalid || b1.if_rvalid) begin
        nrv++;
        n_cmp++;
        if (b1.rdata !== (b1.ls_rvalid ? 16'hA1A1 : 16'hB2B2)) begin
          n_bad++; $display("FAIL b2b_rdata: ls_rvalid %b rdata %h", b1.ls_rvalid, b1.rdata);
        end
      end
      pb2 = pb;
      pb  = b1.busy;
    end
    n_cmp++;
    if (ng != 4 || nrv != 4) begin
      n_bad++; $display("FAIL b2b_count: grants %0d rvalids %0d want 4 4", ng, nrv);
    end
  endtask

  task automatic test_rd_lat3();
    logic [1:0] exp_st [4] = '{ST_ACCESS, ST_WAIT, ST_WAIT, ST_RESP};
    b3.ls_req = 1'b1; b3.ls_we = 1'b0; b3.ls_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) b3.ls_req = 1'b0;
      n_cmp++;
      if ({dut3.state_q, b3.mem_addr, b3.ls_rvalid, b3.msel} !== {exp_st[i], 8'h20, 1'b0, 1'b1}) begin
        n_bad++; $display("FAIL lat3_seq: step %0d state %0d addr %h rvalid %b msel %b want %0d 20 0 1",
          i, dut3.state_q, b3.mem_addr, b3.ls_rvalid, b3.msel, exp_st[i]);
      end
    end
    step();
    n_cmp++;
    if ({b3.ls_rvalid, b3.if_rvalid, b3.rdata, b3.mem_addr} !== {2'b10, 16'hBEEF, 8'h20}) begin
      n_bad++; $display("FAIL lat3_rvalid: ls %b if %b rdata %h addr %h want 1 0 beef 20",
        b3.ls_rvalid, b3.if_rvalid, b3.rdata, b3.mem_addr);
    end
  endtask

  task automatic test_wait_fetch();
    int early = 0;
    b3.ls_req = 1'b1; b3.ls_we = 1'b0; b3.ls_addr = 8'h21;
    step();  // ACCESS for load
    b3.ls_req = 1'b0;
    step();  // first WAIT: fetch arrives
    b3.if_req = 1'b1; b3.if_addr = 8'h22;
    for (int i = 0; i < 2; i++) begin  // WAIT, RESP
      step();
      early += int'(b3.if_gnt);
    end
    step();  // IDLE: load completes
    early += int'(b3.if_gnt);
    n_cmp++;
    if ({b3.ls_rvalid, b3.rdata, early[0]} !== {1'b1, 16'h5A5A, 1'b0} || early != 0) begin
      n_bad++; $display("FAIL wfetch_load: rvalid %b rdata %h early gnts %0d want 1 5a5a 0",
        b3.ls_rvalid, b3.rdata, early);
    end
    step();  // ACCESS for fetch
    n_cmp++;
    if ({b3.if_gnt, b3.mem_addr, b3.msel} !== {1'b1, 8'h22, 1'b0}) begin
      n_bad++; $display("FAIL wfetch_gnt: gnt %b addr %h msel %b want 1 22 0", b3.if_gnt, b3.mem_addr, b3.msel);
    end
    b3.if_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if ({b3.if_rvalid, b3.rdata} !== {1'b1, 16'h0F0F}) begin
      n_bad++; $display("FAIL wfetch_rvalid: rvalid %b rdata %h want 1 0f0f", b3.if_rvalid, b3.rdata);
    end
  endtask

  task automatic test_reset_mid_wait();
    int rvs = 0;
    bit got_if = 0;
    b3.ls_req = 1'b1; b3.ls_we = 1'b0; b3.ls_addr = 8'h20;
    step();
    b3.ls_req = 1'b0;
    step();  // WAIT
    #2 reset3 = 1'b0;
    #1;
    n_cmp++;
    if ({b3.busy, b3.if_gnt, b3.ls_gnt, b3.if_rvalid, b3.ls_rvalid, b3.mem_write, b3.msel} !== 7'b0 ||
        {b3.mem_addr, b3.mem_din, b3.rdata} !== 40'h0) begin
      n_bad++; $display("FAIL midreset_outputs: busy %b msel %b addr %h din %h rdata %h want all 0",
        b3.busy, b3.msel, b3.mem_addr, b3.mem_din, b3.rdata);
    end
    step();
    #2 reset3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      rvs += int'(b3.ls_rvalid) + int'(b3.if_rvalid);
    end
    n_cmp++;
    if (rvs != 0 || dut3.state_q !== ST_IDLE) begin
      n_bad++; $display("FAIL midreset_quiet: rvalids %0d state %0d want 0 0", rvs, dut3.state_q);
    end
    b3.ls_req = 1'b1; b3.ls_addr = 8'h20;
    b3.if_req = 1'b1; b3.if_addr = 8'h22;
    step();
    n_cmp++;
    if ({b3.ls_gnt, b3.if_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL midreset_first_contention: ls_gnt %b if_gnt %b want 1 0", b3.ls_gnt, b3.if_gnt);
    end
    b3.ls_req = 1'b0;
    for (int i = 0; i < 10 && !got_if; i++) begin
      step();
      if (b3.if_gnt) got_if = 1;
    end
    b3.if_req = 1'b0;
    n_cmp++;
    if (!got_if) begin
      n_bad++; $display("FAIL midreset_second_gnt: if_gnt not seen within 10 cycles");
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_rd_lat3();
    test_wait_fetch();
    test_reset_mid_wait();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
